// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_param block.
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   fifo_status_t         : bundle of the four occupancy flags
//   ptr_w(depth)          : pointer width = index bits + one wrap bit
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Bus interface for sync_fifo_param.
//   data_in, w_fifo, r_fifo      : driven by the user (master)
//   data_out, rd_valid           : registered read data and its strobe
//   full, empty, almost_full,
//   almost_empty, count          : occupancy status from the FIFO (slave)
//   overflow, underflow          : sticky error flags, present only when
//                                  SYNC_FIFO_ERR_FLAGS_EN is defined
//
// Handshake: a write is taken on a rising edge where w_fifo=1 and full=0;
// a read is taken on a rising edge where r_fifo=1 and empty=0. Requests
// against the opposite flag are dropped. rd_valid marks the cycle after
// a taken read, when data_out carries that word.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic [WIDTH-1:0]        data_in;
  logic                    w_fifo;
  logic                    r_fifo;
  logic [WIDTH-1:0]        data_out;
  logic                    rd_valid;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ptr_w(DEPTH)-1:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                    overflow;
  logic                    underflow;
`endif

  modport master (
    output data_in, w_fifo, r_fifo,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  data_in, w_fifo, r_fifo,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH register array for sync_fifo_param.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index (combinational read)
//   rdata : word at raddr
// Contents are deliberately not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock synchronous FIFO with parametrised width and depth.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sync_fifo_param_if.slave (data, requests, read data, status)
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs on the bus.
// Status flags and count are decoded from the pointers only, so no input
// reaches an output without passing through a register.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] AE_LEVEL = PW'(AE_MARGIN);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    occ;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] dout_q;
  logic             rv_q;
  logic             wr_acc;
  logic             rd_acc;
  fifo_status_t     status;

  // Modular pointer difference is the occupancy, 0..DEPTH.
  assign occ = wr_ptr - rd_ptr;

  // Same slot with opposite wrap bits means the writer lapped the reader.
  assign status.full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                               (wr_ptr[AW] != rd_ptr[AW]);
  assign status.empty        = (wr_ptr == rd_ptr);
  assign status.almost_full  = (occ >= AF_LEVEL);
  assign status.almost_empty = (occ <= AE_LEVEL);

  assign wr_acc = bus.w_fifo && !status.full;
  assign rd_acc = bus.r_fifo && !status.empty;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
        dout_q <= rd_word;
      end
      rv_q <= rd_acc;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.rd_valid     = rv_q;
  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.count        = occ;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky: any request against the blocking flag latches until reset,
  // including the combined read+write cases at full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.w_fifo && status.full)  ovf_q <= 1'b1;
      if (bus.r_fifo && status.empty) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule
